// File: rtl/instr_fetch_stage_if.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage_if
//   Instruction-memory fetch port shared by the fetch stage and the memory.
//   Each transaction completes at the rising edge where req and ready are both 1.
//
//   Signals
//     req    fetch request. Held, with addr stable, until ready.
//     addr   32-bit word address. Bits [1:0] are always 0.
//     rdata  instruction word. Valid in the cycle where ready = 1.
//     ready  memory response strobe.
//
//   Modports
//     master  fetch-stage side: drives req/addr, samples rdata/ready.
//     slave   memory side: samples req/addr, drives rdata/ready.
// ---------------------------------------------------------------------------
interface instr_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic [31:0] rdata;
   logic        ready;

   modport master (output req, output addr, input rdata, input ready);
   modport slave  (input req, input addr, output rdata, output ready);
endinterface

// File: rtl/instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// instr_fetch_stage
//   Instruction-fetch stage feeding the control decoder. It holds the PC and
//   fetches one 32-bit word per memory transaction, with at most one
//   transaction outstanding. The word is presented in an IF/ID output
//   register together with its decoder fields. The stage supports a
//   downstream stall, and a branch/jump redirect that flushes the in-flight
//   and held instructions.
//
//   Parameters
//     RESET_PC     PC loaded on reset (word aligned)
//     PC_STEP      PC increment per accepted instruction
//
//   Ports
//     clk          clock; all state updates on the rising edge
//     rst          asynchronous, active-high reset
//     imem         instruction-memory port (master side: req/addr out, rdata/ready in)
//     stall        downstream cannot accept; the output register holds
//     redirect     branch/jump taken; discard the in-flight and held words
//     redirect_pc  new fetch address; bits [1:0] are forced to 0
//     out_valid    output register holds a live instruction
//     out_pc       address of out_instr
//     out_instr    fetched word
//     out_opcode   out_instr[31:26]
//     out_rs       out_instr[25:21]
//     out_rt       out_instr[20:16]
//     out_rd       out_instr[15:11]
//     out_funct    out_instr[5:0]
//     out_imm16    out_instr[15:0]
// ---------------------------------------------------------------------------
module instr_fetch_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_3000,
   parameter logic [31:0] PC_STEP  = 32'd4
) (
   input  logic                       clk,
   input  logic                       rst,
   instr_fetch_stage_if.master        imem,
   input  logic                       stall,
   input  logic                       redirect,
   input  logic [31:0]                redirect_pc,
   output logic                       out_valid,
   output logic [31:0]                out_pc,
   output logic [31:0]                out_instr,
   output logic [5:0]                 out_opcode,
   output logic [5:0]                 out_funct,
   output logic [4:0]                 out_rs,
   output logic [4:0]                 out_rt,
   output logic [4:0]                 out_rd,
   output logic [15:0]                out_imm16
);

   // BOOT : one idle cycle after reset release
   // FETCH: request outstanding at pc
   // DRAIN: finishing a request made stale by a redirect; its response is dropped
   // HOLD : skid buffer full behind a stalled output; no request
   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      FETCH = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } state_t;

   state_t      state;
   state_t      state_next;

   logic [31:0] pc;
   logic [31:0] drain_addr;
   logic        skid_vld;
   logic [31:0] skid_instr;
   logic [31:0] skid_pc;

   logic        accept;
   logic        xfer;
   logic        capture;
   logic        skid_load;
   logic        skid_drain;
   logic [31:0] redirect_pc_al;
   logic [31:0] pc_inc;

   // ------------------------------------------------------------------------
   // Handshake decode
   // ------------------------------------------------------------------------
   // The output register can take a word when it is empty or being consumed now.
   assign accept         = !out_valid || !stall;
   assign xfer           = imem.req && imem.ready;
   assign redirect_pc_al = redirect_pc & ~32'd3;
   assign pc_inc         = pc + PC_STEP;

   // Redirect takes priority over everything else. A response that completes
   // in the redirect cycle is simply not captured.
   assign capture    = (state == FETCH) && xfer &&  accept && !redirect;
   // Stall rose while the request was already out: park the word instead of
   // dropping the request, which would violate the hold-until-ready protocol.
   assign skid_load  = (state == FETCH) && xfer && !accept && !redirect;
   assign skid_drain = (state == HOLD) && skid_vld && !stall && !redirect;

   // ------------------------------------------------------------------------
   // FSM: state register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= BOOT;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------------
   // FSM: next-state logic
   // ------------------------------------------------------------------------
   always_comb begin
      state_next = state;
      unique case (state)
         BOOT: begin
            state_next = FETCH;
         end
         FETCH: begin
            if (redirect) begin
               // A request still waiting for ready must be completed before refetching.
               state_next = xfer ? FETCH : DRAIN;
            end else if (xfer && !accept) begin
               state_next = HOLD;
            end else begin
               state_next = FETCH;
            end
         end
         DRAIN: begin
            // A redirect here only moves pc; the stale request still has to finish.
            state_next = xfer ? FETCH : DRAIN;
         end
         HOLD: begin
            if (redirect || !stall) begin
               state_next = FETCH;
            end else begin
               state_next = HOLD;
            end
         end
         default: begin
            state_next = BOOT;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // FSM: outputs
   // ------------------------------------------------------------------------
   always_comb begin
      imem.req  = 1'b0;
      imem.addr = pc;
      unique case (state)
         FETCH: begin
            imem.req  = 1'b1;
            imem.addr = pc;
         end
         DRAIN: begin
            // pc has already moved to the redirect target; keep the old address
            // on the bus until the stale transaction completes.
            imem.req  = 1'b1;
            imem.addr = drain_addr;
         end
         default: begin
            imem.req  = 1'b0;
            imem.addr = pc;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Program counter (wraps modulo 2^32)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc <= RESET_PC;
      end else if (redirect) begin
         pc <= redirect_pc_al;
      end else if (capture || skid_load) begin
         pc <= pc_inc;
      end
   end

   // Address of the request being drained; only meaningful in DRAIN.
   always_ff @(posedge clk) begin
      if ((state == FETCH) && redirect && !xfer) begin
         drain_addr <= pc;
      end
   end

   // ------------------------------------------------------------------------
   // Skid buffer (one entry)
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         skid_vld <= 1'b0;
      end else if (redirect) begin
         skid_vld <= 1'b0;
      end else if (skid_load) begin
         skid_vld <= 1'b1;
      end else if (skid_drain) begin
         skid_vld <= 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_instr <= imem.rdata;
         skid_pc    <= pc;
      end
   end

   // ------------------------------------------------------------------------
   // IF/ID output register
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_valid <= 1'b0;
      end else if (redirect) begin
         out_valid <= 1'b0;
      end else if (capture || skid_drain) begin
         out_valid <= 1'b1;
      end else if (!stall) begin
         // Consumed this cycle with nothing new behind it.
         out_valid <= 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         out_pc    <= 32'd0;
         out_instr <= 32'd0;
      end else if (capture) begin
         out_pc    <= pc;
         out_instr <= imem.rdata;
      end else if (skid_drain) begin
         out_pc    <= skid_pc;
         out_instr <= skid_instr;
      end
   end

   // Decoder fields are plain slices of the held word.
   assign out_opcode = out_instr[31:26];
   assign out_rs     = out_instr[25:21];
   assign out_rt     = out_instr[20:16];
   assign out_rd     = out_instr[15:11];
   assign out_funct  = out_instr[5:0];
   assign out_imm16  = out_instr[15:0];

   // A request that has not yet been answered keeps its request and address.
   req_hold_a : assert property (@(posedge clk) disable iff (rst)
      (imem.req && !imem.ready) |=> (imem.req && $stable(imem.addr)));

endmodule

// File: tb/tb_instr_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_instr_fetch_stage
//   Self-checking bench for instr_fetch_stage. The memory is a pure function
//   of the address with a configurable or random response latency. The
//   reference model tracks the expected architectural instruction stream:
//   each consumed word must carry the next program-order pc and the memory
//   word at that pc, and a redirect restarts the stream at the target.
// ---------------------------------------------------------------------------
module tb_instr_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = 32'd0;
   logic        out_valid;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [5:0]  out_opcode;
   logic [5:0]  out_funct;
   logic [4:0]  out_rs;
   logic [4:0]  out_rt;
   logic [4:0]  out_rd;
   logic [15:0] out_imm16;

   instr_fetch_stage_if imem ();

   instr_fetch_stage #(
      .RESET_PC (32'h0000_3000),
      .PC_STEP  (32'd4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .imem        (imem),
      .stall       (stall),
      .redirect    (redirect),
      .redirect_pc (redirect_pc),
      .out_valid   (out_valid),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_opcode  (out_opcode),
      .out_funct   (out_funct),
      .out_rs      (out_rs),
      .out_rt      (out_rt),
      .out_rd      (out_rd),
      .out_imm16   (out_imm16)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // reference model state
   int          mem_lat;     // fixed latency, or -1 for random 0..3
   int          lat_left;    // -1: no transaction in progress
   logic [31:0] exp_pc;
   int          idle;
   logic        prev_pend, prev_redir, prev_hold;
   logic [31:0] prev_addr, prev_pc, prev_instr;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h0000_3000) return 32'h2008_0005;
      return (a * 32'h9E37_79B1) ^ 32'h0F1E_2D3C;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clear_model();
      lat_left   = -1;
      exp_pc     = 32'h0000_3000;
      idle       = 0;
      prev_pend  = 1'b0;
      prev_redir = 1'b0;
      prev_hold  = 1'b0;
      prev_addr  = 32'd0;
      prev_pc    = 32'd0;
      prev_instr = 32'd0;
   endtask

   // Assert reset (at any time), check the immediate reset values, release on a negedge.
   task automatic do_reset();
      rst = 1'b1;
      stall = 1'b0;
      redirect = 1'b0;
      redirect_pc = 32'd0;
      imem.ready = 1'b0;
      imem.rdata = 32'd0;
      #1;
      check("rst_valid", out_valid, 0);
      check("rst_pc", out_pc, 0);
      check("rst_instr", out_instr, 0);
      check("rst_fields", {out_opcode, out_rs, out_rt, out_imm16}, 0);
      check("rst_rd_funct", {21'd0, out_rd, out_funct}, 0);
      check("rst_req", imem.req, 0);
      check("rst_addr", imem.addr, 32'h0000_3000);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      clear_model();
      check("boot_req", imem.req, 0);
   endtask

   // One clock: check invariants, drive inputs and memory at the negedge,
   // update the model, then return #1 after the rising edge.
   task automatic tick(input logic s, input logic rd, input logic [31:0] rpc);
      @(negedge clk);
      check("addr_align", {30'd0, imem.addr[1:0]}, 0);
      check("fields_hi", {out_opcode, out_rs, out_rt, out_imm16}, out_instr);
      check("fields_lo", {21'd0, out_rd, out_funct}, {21'd0, out_instr[15:11], out_instr[5:0]});
      if (prev_pend) begin
         check("req_held", imem.req, 1);
         check("addr_held", imem.addr, prev_addr);
      end
      if (prev_redir) check("valid_after_redirect", out_valid, 0);
      if (prev_hold) begin
         check("hold_valid", out_valid, 1);
         check("hold_pc", out_pc, prev_pc);
         check("hold_instr", out_instr, prev_instr);
      end
      if (out_valid) check("instr_word", out_instr, mem_word(out_pc));

      stall = s;
      redirect = rd;
      redirect_pc = rpc;
      if (imem.req) begin
         if (lat_left < 0) lat_left = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 3));
         if (lat_left == 0) begin
            imem.ready = 1'b1;
            imem.rdata = mem_word(imem.addr);
         end else begin
            imem.ready = 1'b0;
            imem.rdata = $urandom;
            lat_left--;
         end
      end else begin
         imem.ready = 1'($urandom_range(0, 1));
         imem.rdata = $urandom;
      end

      if (out_valid && !s) begin
         check("seq_pc", out_pc, exp_pc);
         exp_pc = exp_pc + 32'd4;
         idle = 0;
      end else begin
         idle++;
      end
      if (rd) exp_pc = rpc & ~32'd3;
      if (idle > 60) begin
         check("progress_timeout", idle, 0);
         idle = 0;
      end

      prev_pend  = imem.req && !imem.ready;
      prev_addr  = imem.addr;
      prev_redir = rd;
      prev_hold  = out_valid && s && !rd;
      prev_pc    = out_pc;
      prev_instr = out_instr;
      if (imem.req && imem.ready) lat_left = -1;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int n;
      logic [31:0] wrap_exp [4];
      clear_model();
      mem_lat = 0;
      imem.ready = 1'b0;
      imem.rdata = 32'd0;
      #3;

      // zero-wait memory, no stall: one instruction per cycle
      do_reset();
      for (int k = 0; k < 3; k++) begin
         tick(1'b0, 1'b0, 32'd0);
         check("zw_valid", out_valid, 1);
         check("zw_pc", out_pc, 32'h0000_3000 + 32'(4 * k));
      end

      // stall for 4 cycles with 0x2008_0005 held
      do_reset();
      tick(1'b0, 1'b0, 32'd0);
      for (int k = 0; k < 4; k++) begin
         tick(1'b1, 1'b0, 32'd0);
         check("st_valid", out_valid, 1);
         check("st_pc", out_pc, 32'h0000_3000);
         check("st_instr", out_instr, 32'h2008_0005);
         check("st_opcode", out_opcode, 32'h08);
         check("st_rt", out_rt, 32'd8);
         check("st_imm16", out_imm16, 32'h0005);
      end
      tick(1'b0, 1'b0, 32'd0);
      check("st_rel_pc", out_pc, 32'h0000_3004);
      tick(1'b0, 1'b0, 32'd0);
      check("st_rel_pc2", out_pc, 32'h0000_3008);

      // three-cycle memory: req/addr held three cycles per fetch
      do_reset();
      mem_lat = 2;
      for (int k = 0; k < 3; k++) begin
         n = 0;
         do begin
            tick(1'b0, 1'b0, 32'd0);
            n++;
         end while (!out_valid && n < 10);
         check("lat_cycles", n, 3);
         check("lat_pc", out_pc, 32'h0000_3000 + 32'(4 * k));
      end

      // redirect to 0x3043 while a fetch is pending
      do_reset();
      mem_lat = 0;
      tick(1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'd0);
      mem_lat = 4;
      tick(1'b1, 1'b0, 32'd0);
      tick(1'b0, 1'b1, 32'h0000_3043);
      check("rd_valid", out_valid, 0);
      check("rd_drain_req", imem.req, 1);
      check("rd_drain_addr", imem.addr, 32'h0000_3008);
      n = 0;
      do begin
         tick(1'b0, 1'b0, 32'd0);
         n++;
      end while (!out_valid && n < 20);
      check("rd_new_valid", out_valid, 1);
      check("rd_new_pc", out_pc, 32'h0000_3040);

      // redirect, stall and ready in the same cycle
      mem_lat = 0;
      tick(1'b1, 1'b1, 32'h0000_5000);
      check("rsr_valid", out_valid, 0);
      tick(1'b0, 1'b0, 32'd0);
      check("rsr_pc", out_pc, 32'h0000_5000);

      // pc wraps modulo 2^32
      wrap_exp[0] = 32'hFFFF_FFF8;
      wrap_exp[1] = 32'hFFFF_FFFC;
      wrap_exp[2] = 32'h0000_0000;
      wrap_exp[3] = 32'h0000_0004;
      tick(1'b0, 1'b1, 32'hFFFF_FFF9);
      for (int k = 0; k < 4; k++) begin
         tick(1'b0, 1'b0, 32'd0);
         check("wrap_pc", out_pc, wrap_exp[k]);
      end

      // reset in the middle of a transaction
      mem_lat = 3;
      tick(1'b0, 1'b0, 32'd0);
      tick(1'b0, 1'b0, 32'd0);
      #2;
      do_reset();
      mem_lat = 0;
      tick(1'b0, 1'b0, 32'd0);
      check("rst_refetch_pc", out_pc, 32'h0000_3000);

      // randomized traffic against the stream model
      mem_lat = -1;
      for (int k = 0; k < 1500; k++) begin
         tick(1'($urandom_range(0, 9) < 3), 1'($urandom_range(0, 19) == 0), $urandom);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
